// File: rtl/cpu_pkg.sv
// Shared encodings for the sequencer: FSM states, opcodes, PC-select codes
// and the condition-code reset value.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [2:0] CC_RESET = 3'b010;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/cc_reg.sv
// Condition-code register {N,Z,P} with one-hot qualified update and
// branch-taken evaluation against the instruction's condition mask.
module cc_reg
    import cpu_pkg::*;
(
    input  logic       clka,
    input  logic       reset,
    input  logic       update,
    input  logic [2:0] alu_flags,
    input  logic [2:0] br_mask,
    output logic [2:0] cc,
    output logic       taken
);

    logic one_hot;

    // Malformed flag sets (none or several bits high) must not corrupt CC.
    assign one_hot = (alu_flags == 3'b100) || (alu_flags == 3'b010) || (alu_flags == 3'b001);

    always_ff @(posedge clka) begin
        if (reset) begin
            cc <= CC_RESET;
        end else if (update && one_hot) begin
            cc <= alu_flags;
        end
    end

    assign taken = |(br_mask & cc);

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback
// control strobes, memory wait timeout with sticky fault, and HALT.
module seq_ctrl
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clka,
    input  logic       reset_in,
    input  logic [3:0] opcode_in,
    input  logic       n_dec_in,
    input  logic       z_dec_in,
    input  logic       p_dec_in,
    input  logic       n_alu_in,
    input  logic       z_alu_in,
    input  logic       p_alu_in,
    input  logic       mem_ready_in,
    output logic       mem_req_out,
    output logic       mem_we_out,
    output logic       ir_we_out,
    output logic [1:0] pc_ctl_out,
    output logic       we_reg_out,
    output logic [2:0] state_out,
    output logic [2:0] cc_out,
    output logic       fault_out
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic            waiting;
    logic            timeout;
    logic            cc_update;
    logic            taken;

    cc_reg u_cc_reg (
        .clka      (clka),
        .reset     (reset_in),
        .update    (cc_update),
        .alu_flags ({n_alu_in, z_alu_in, p_alu_in}),
        .br_mask   ({n_dec_in, z_dec_in, p_dec_in}),
        .cc        (cc_out),
        .taken     (taken)
    );

    assign waiting   = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready_in;
    assign state_out = state;

    always_ff @(posedge clka) begin
        if (reset_in) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            fault_out <= 1'b0;
        end else begin
            state     <= state_next;
            fault_out <= fault_out | timeout;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // A memory response has priority over the timeout in the same cycle.
    always_comb begin
        state_next  = state;
        mem_req_out = 1'b0;
        mem_we_out  = 1'b0;
        ir_we_out   = 1'b0;
        pc_ctl_out  = PC_HOLD;
        we_reg_out  = 1'b0;
        cc_update   = 1'b0;
        timeout     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req_out = 1'b1;
                if (mem_ready_in) begin
                    ir_we_out  = 1'b1;
                    pc_ctl_out = PC_INC;
                    state_next = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                if (is_alu_op(opcode_in)) begin
                    we_reg_out = 1'b1;
                    cc_update  = 1'b1;
                end else begin
                    case (opcode_in)
                        OP_BR:   pc_ctl_out = taken ? PC_BRANCH : PC_HOLD;
                        OP_JMP:  pc_ctl_out = PC_JUMP;
                        OP_LD,
                        OP_ST:   state_next = S_MEM;
                        OP_HALT: state_next = S_HALT;
                        default: state_next = S_FETCH;
                    endcase
                end
            end
            S_MEM: begin
                mem_req_out = 1'b1;
                mem_we_out  = (opcode_in == OP_ST);
                if (mem_ready_in) begin
                    state_next = (opcode_in == OP_LD) ? S_WB : S_FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_WB: begin
                we_reg_out = 1'b1;
                cc_update  = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Reset silences every strobe, whatever the current state.
        if (reset_in) begin
            mem_req_out = 1'b0;
            mem_we_out  = 1'b0;
            ir_we_out   = 1'b0;
            pc_ctl_out  = PC_HOLD;
            we_reg_out  = 1'b0;
            cc_update   = 1'b0;
            timeout     = 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: instruction-level model expands each instruction into
// its per-cycle expectations; a negedge process compares every cycle.
module tb_seq_ctrl;

    localparam int FETCH  = 0;
    localparam int DECODE = 1;
    localparam int EXEC   = 2;
    localparam int MEM    = 3;
    localparam int WB     = 4;
    localparam int HALT   = 5;

    logic       clka;
    logic       reset_in;
    logic [3:0] opcode_in;
    logic       n_dec_in, z_dec_in, p_dec_in;
    logic       n_alu_in, z_alu_in, p_alu_in;
    logic       mem_ready_in;
    logic       mem_req_out, mem_we_out, ir_we_out, we_reg_out, fault_out;
    logic [1:0] pc_ctl_out;
    logic [2:0] state_out, cc_out;

    int checks = 0;
    int errors = 0;

    logic [2:0] model_cc    = 3'b010;
    logic       model_fault = 1'b0;
    logic [3:0] cur_op      = 4'b0000;
    logic [2:0] cur_mask    = 3'b000;
    logic [2:0] cur_flags   = 3'b000;

    bit         exp_valid = 1'b0;
    logic [2:0] exp_state;
    logic       exp_req, exp_we, exp_irwe, exp_wereg, exp_fault;
    logic [1:0] exp_pc;
    logic [2:0] exp_cc;

    seq_ctrl #(.WAIT_MAX(15)) dut (
        .clka         (clka),
        .reset_in     (reset_in),
        .opcode_in    (opcode_in),
        .n_dec_in     (n_dec_in),
        .z_dec_in     (z_dec_in),
        .p_dec_in     (p_dec_in),
        .n_alu_in     (n_alu_in),
        .z_alu_in     (z_alu_in),
        .p_alu_in     (p_alu_in),
        .mem_ready_in (mem_ready_in),
        .mem_req_out  (mem_req_out),
        .mem_we_out   (mem_we_out),
        .ir_we_out    (ir_we_out),
        .pc_ctl_out   (pc_ctl_out),
        .we_reg_out   (we_reg_out),
        .state_out    (state_out),
        .cc_out       (cc_out),
        .fault_out    (fault_out)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic compareField(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput();
        compareField("state",   {5'b0, state_out},   {5'b0, exp_state});
        compareField("mem_req", {7'b0, mem_req_out}, {7'b0, exp_req});
        compareField("mem_we",  {7'b0, mem_we_out},  {7'b0, exp_we});
        compareField("ir_we",   {7'b0, ir_we_out},   {7'b0, exp_irwe});
        compareField("pc_ctl",  {6'b0, pc_ctl_out},  {6'b0, exp_pc});
        compareField("we_reg",  {7'b0, we_reg_out},  {7'b0, exp_wereg});
        compareField("cc",      {5'b0, cc_out},      {5'b0, exp_cc});
        compareField("fault",   {7'b0, fault_out},   {7'b0, exp_fault});
    endtask

    always @(negedge clka) begin
        if (exp_valid) checkOutput();
    end

    // One cycle: drive inputs, publish expectations, then advance the model.
    task automatic applyStimulus(input int st, input logic ready, input logic req,
                                 input logic we, input logic irwe, input logic [1:0] pc,
                                 input logic wereg, input bit cc_upd, input bit rst,
                                 input bit pin_pc, input logic [1:0] pin_val);
        reset_in     = rst;
        mem_ready_in = ready;
        opcode_in    = cur_op;
        {n_dec_in, z_dec_in, p_dec_in} = cur_mask;
        {n_alu_in, z_alu_in, p_alu_in} = cur_flags;
        exp_state = st[2:0];
        exp_req   = req;
        exp_we    = we;
        exp_irwe  = irwe;
        exp_pc    = pc;
        exp_wereg = wereg;
        exp_cc    = model_cc;
        exp_fault = model_fault;
        exp_valid = 1'b1;
        #2;
        if (pin_pc) compareField("pc_pin", {6'b0, pc_ctl_out}, {6'b0, pin_val});
        @(posedge clka);
        #1;
        if (rst) begin
            model_cc    = 3'b010;
            model_fault = 1'b0;
        end else if (cc_upd && $countones(cur_flags) == 1) begin
            model_cc = cur_flags;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [2:0] mask, input logic [2:0] flags,
                             input int fetch_wait, input int mem_wait,
                             input bit pin_pc, input logic [1:0] pin_val);
        logic [1:0] br_pc;
        cur_op    = op;
        cur_mask  = mask;
        cur_flags = flags;
        for (int i = 0; i < fetch_wait; i++)
            applyStimulus(FETCH, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
        applyStimulus(FETCH, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 0, 2'b00);
        // A stray ready in DECODE must be ignored.
        applyStimulus(DECODE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
        case (op)
            4'b0001, 4'b0101, 4'b1001:
                applyStimulus(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1, 0, pin_pc, pin_val);
            4'b0000: begin
                br_pc = (|(mask & model_cc)) ? 2'b10 : 2'b00;
                applyStimulus(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, br_pc, 1'b0, 0, 0, pin_pc, pin_val);
            end
            4'b1100:
                applyStimulus(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0, 0, pin_pc, pin_val);
            4'b0010, 4'b0011: begin
                applyStimulus(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, pin_pc, pin_val);
                for (int i = 0; i < mem_wait; i++)
                    applyStimulus(MEM, 1'b0, 1'b1, op == 4'b0011, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
                applyStimulus(MEM, 1'b1, 1'b1, op == 4'b0011, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
                if (op == 4'b0010)
                    applyStimulus(WB, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1, 0, 0, 2'b00);
            end
            default:
                applyStimulus(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, pin_pc, pin_val);
        endcase
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_in = 1'b1;
        opcode_in = 4'b0000;
        {n_dec_in, z_dec_in, p_dec_in} = 3'b000;
        {n_alu_in, z_alu_in, p_alu_in} = 3'b000;
        mem_ready_in = 1'b1;
        @(posedge clka);
        #1;
        applyStimulus(FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1, 0, 2'b00);
        compareField("rst_state", {5'b0, state_out}, 8'd0);
        compareField("rst_cc",    {5'b0, cc_out},    8'h02);
        compareField("rst_fault", {7'b0, fault_out}, 8'd0);

        // Branches against cc=010: taken, not taken, and empty mask.
        run_instr(4'b0000, 3'b010, 3'b000, 0, 0, 1, 2'b10);
        run_instr(4'b0000, 3'b101, 3'b000, 0, 0, 1, 2'b00);
        run_instr(4'b0000, 3'b000, 3'b000, 0, 0, 1, 2'b00);

        run_instr(4'b0001, 3'b000, 3'b100, 0, 0, 0, 2'b00);
        compareField("add_cc", {5'b0, cc_out}, 8'h04);
        run_instr(4'b0001, 3'b000, 3'b110, 0, 0, 0, 2'b00);
        compareField("add_cc_hold", {5'b0, cc_out}, 8'h04);

        run_instr(4'b1100, 3'b000, 3'b000, 0, 0, 1, 2'b11);
        run_instr(4'b0100, 3'b000, 3'b001, 0, 0, 1, 2'b00);
        run_instr(4'b0010, 3'b000, 3'b001, 0, 2, 0, 2'b00);
        compareField("ld_cc", {5'b0, cc_out}, 8'h01);
        run_instr(4'b0011, 3'b000, 3'b100, 1, 1, 0, 2'b00);
        run_instr(4'b0101, 3'b000, 3'b010, 14, 0, 0, 2'b00);
        compareField("wait14_fault", {7'b0, fault_out}, 8'd0);
        run_instr(4'b1001, 3'b000, 3'b100, 10, 10, 0, 2'b00);
        run_instr(4'b0010, 3'b000, 3'b001, 10, 10, 0, 2'b00);
        compareField("ld_long_cc", {5'b0, cc_out}, 8'h01);

        // Reset while a load waits in MEM abandons it; ready in the next fetch counts.
        cur_op = 4'b0010; cur_flags = 3'b100;
        applyStimulus(FETCH, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 0, 2'b00);
        applyStimulus(DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
        applyStimulus(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
        applyStimulus(MEM, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
        applyStimulus(MEM, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1, 0, 2'b00);
        run_instr(4'b0001, 3'b000, 3'b001, 0, 0, 0, 2'b00);
        compareField("post_rst_cc", {5'b0, cc_out}, 8'h01);

        // Fetch starved for the full wait budget.
        cur_op = 4'b0001;
        for (int i = 0; i < 15; i++)
            applyStimulus(FETCH, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
        model_fault = 1'b1;
        compareField("to_fault", {7'b0, fault_out}, 8'd1);
        compareField("to_state", {5'b0, state_out}, 8'd5);
        for (int i = 0; i < 3; i++)
            applyStimulus(HALT, i[0], 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
        applyStimulus(HALT, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1, 0, 2'b00);
        compareField("to_rst_state", {5'b0, state_out}, 8'd0);
        compareField("to_rst_fault", {7'b0, fault_out}, 8'd0);
        compareField("to_rst_cc",    {5'b0, cc_out},    8'h02);

        // HALT opcode: strobes stay quiet despite ready pulses.
        run_instr(4'b1111, 3'b000, 3'b000, 0, 0, 0, 2'b00);
        for (int i = 0; i < 10; i++)
            applyStimulus(HALT, ~i[0], 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 2'b00);
        compareField("halt_state", {5'b0, state_out}, 8'd5);
        applyStimulus(HALT, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1, 0, 2'b00);
        run_instr(4'b0001, 3'b000, 3'b100, 0, 0, 0, 2'b00);

        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
